multiply_divide_unit: RTL and testbench
=======================================

# multiply_divide_unit

Iterative multiply/divide unit with architectural HI/LO registers, attached beside the single-cycle datapath's ALU. Consumes the register-file read operands (srca/srcb) for mult, multu, div, divu, mthi, mtlo, and provides HI/LO to the result mux for mfhi/mflo. Runs one shift-add/restoring-subtract iteration per clock and raises busy so the controller can stall the PC while an operation is in flight.

## Interface
- No parameters; datapath width is fixed at 32 bits, HI/LO at 32 bits each.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  request a new operation; sampled on the rising edge.
- op  in  2  operation code: 00 multu, 01 mult, 10 divu, 11 div.
- a  in  32  operand A (srca): multiplicand/dividend; source for mthi/mtlo.
- b  in  32  operand B (srcb): multiplier/divisor.
- mthi  in  1  write a into HI.
- mtlo  in  1  write a into LO.
- busy  out  1  operation in progress; the controller stalls the PC while high.
- done  out  1  single-cycle pulse when the HI/LO result has been committed.
- hi  out  32  HI register (product[63:32] / remainder).
- lo  out  32  LO register (product[31:0] / quotient).

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE: busy=0.
  - start=1: latch op, |a|, |b| and result sign bits, clear count, go to RUN.
  - Otherwise, mthi/mtlo write a into HI/LO on that edge. If both are set, both registers are written.
- start has priority over mthi/mtlo on the same edge. mthi/mtlo are ignored that edge.
- RUN: one iteration per edge, count 0..31. After the iteration with count=31, go to FIX.
  - Multiply: unsigned shift-add of magnitudes into a 64-bit accumulator.
  - Divide: restoring division of magnitudes, producing a 32-bit quotient and a 32-bit remainder.
- FIX: apply sign correction, write hi/lo, go to IDLE, and pulse done for the following cycle.
  - mult: negate the 64-bit product if a[31]^b[31].
  - div: negate the quotient if a[31]^b[31]; negate the remainder if a[31].
  - Unsigned ops use no sign correction.
- Operands are captured at start; a and b may change freely afterwards.
- start, mthi and mtlo are ignored while busy=1. There is no queueing.
- Divide by zero (div or divu): lo=0xFFFFFFFF, hi=a as latched. Full latency is kept; no exception is raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- hi/lo hold their previous values until the FIX commit edge. No partial results are ever visible.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, count=0.
- Reset assertion mid-operation aborts immediately. No result is written and the next start is accepted normally.
- Edge E0 (start accepted in IDLE): busy=1 from just after E0.
- Edges E1..E32: the 32 RUN iterations.
- Edge E33: FIX commit. hi/lo are valid just after E33, busy=0, and done=1 for exactly one cycle.
- Latency: 33 cycles from the accepting edge to the commit edge. All four ops have identical latency, including divide-by-zero.
- A new start is accepted on E34 (the cycle in which done=1). Back-to-back operations are allowed.
- mthi/mtlo take effect on the same edge (1-cycle write). hi/lo reflect the new value just after that edge.
- Outputs busy, done, hi and lo are registered, with no combinational path from the inputs.

## Test plan
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; busy high for exactly 33 cycles; single done pulse after E33.
- mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
- div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mtlo a=0x12345678 while idle -> lo=0x12345678 next edge.
  - A start multu 3*4 followed by mthi and a second start while busy -> second start and mthi ignored; final hi=0 lo=12.
  - Start together with mtlo while idle -> mtlo dropped, result written at E33.
- Start divu 100/7, assert reset at count 10, release -> busy=0, hi=lo=0, done never pulses.
  - A following multu 2*3 -> lo=6 after 33 cycles.

Source files
------------

// File: rtl/multiply_divide_unit_if.sv
// Bus bundle between the datapath controller and the iterative multiply/divide unit.
// The master drives the operation request, operands and HI/LO writes.
// The slave returns busy/done and the architectural HI/LO registers.
interface multiply_divide_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/multiply_divide_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// It runs 32 iterations of shift-add (multiply) or restoring subtraction (divide)
// on operand magnitudes, then applies sign correction in a single commit cycle.
// A single 64-bit accumulator is shared by both operations:
//   multiply: {partial product high, multiplier bits still to consume}
//   divide  : {partial remainder, dividend bits / quotient bits}
module multiply_divide_unit (
  input logic                    clk,
  input logic                    reset,
  multiply_divide_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's complement negation helpers.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    neg32 = ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    neg64 = ~x + 64'd1;
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [4:0]  count_r;
  logic        is_div_r;
  logic        neg_res_r;   // negate product or quotient
  logic        neg_rem_r;   // negate remainder (signed divide, negative dividend)
  logic        b_zero_r;    // divisor was zero at start
  logic [31:0] opnd_r;      // |a| for multiply, |b| for divide
  logic [63:0] acc_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_shift_s;
  logic        div_sub_s;
  logic [31:0] div_rem_s;
  logic [63:0] div_next_s;
  logic [63:0] fix_prod_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // Operand magnitudes: only the signed ops (op[0]=1) take an absolute value.
  always_comb begin
    mag_a_s = bus.a;
    mag_b_s = bus.b;
    if (bus.op[0] && bus.a[31]) begin
      mag_a_s = neg32(bus.a);
    end else begin
      mag_a_s = bus.a;
    end
    if (bus.op[0] && bus.b[31]) begin
      mag_b_s = neg32(bus.b);
    end else begin
      mag_b_s = bus.b;
    end
  end

  // One shift-add multiply step and one restoring divide step from the accumulator.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]};
    mul_next_s  = acc_r;
    div_shift_s = {acc_r[63:32], acc_r[31]};
    div_sub_s   = 1'b0;
    div_rem_s   = div_shift_s[31:0];
    div_next_s  = acc_r;
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[63:32]};
    end
    mul_next_s = {mul_sum_s, acc_r[31:1]};
    div_sub_s  = (div_shift_s >= {1'b0, opnd_r});
    if (div_sub_s) begin
      div_rem_s = div_shift_s[31:0] - opnd_r;
    end else begin
      div_rem_s = div_shift_s[31:0];
    end
    div_next_s = {div_rem_s, acc_r[30:0], div_sub_s};
  end

  // Sign-corrected results committed to HI/LO in the FIX cycle.
  always_comb begin
    fix_prod_s = acc_r;
    fix_hi_s   = acc_r[63:32];
    fix_lo_s   = acc_r[31:0];
    if (is_div_r) begin
      if (neg_rem_r) begin
        fix_hi_s = neg32(acc_r[63:32]);
      end else begin
        fix_hi_s = acc_r[63:32];
      end
      if (b_zero_r) begin
        fix_lo_s = 32'hFFFF_FFFF;
      end else if (neg_res_r) begin
        fix_lo_s = neg32(acc_r[31:0]);
      end else begin
        fix_lo_s = acc_r[31:0];
      end
    end else begin
      if (neg_res_r) begin
        fix_prod_s = neg64(acc_r);
      end else begin
        fix_prod_s = acc_r;
      end
      fix_hi_s = fix_prod_s[63:32];
      fix_lo_s = fix_prod_s[31:0];
    end
  end

  // Next-state logic for the IDLE -> RUN -> FIX sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == 5'd31) begin
          next_state_s = FIX;
        end else begin
          next_state_s = RUN;
        end
      end
      FIX:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: operand capture, iteration, commit, and direct HI/LO writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r   <= 5'd0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      b_zero_r  <= 1'b0;
      opnd_r    <= 32'd0;
      acc_r     <= 64'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // start wins over mthi/mtlo on the same edge
            is_div_r  <= bus.op[1];
            neg_res_r <= bus.op[0] & (bus.a[31] ^ bus.b[31]);
            neg_rem_r <= bus.op[0] & bus.a[31];
            b_zero_r  <= (bus.b == 32'd0);
            count_r   <= 5'd0;
            busy_r    <= 1'b1;
            if (bus.op[1]) begin
              opnd_r <= mag_b_s;
              acc_r  <= {32'd0, mag_a_s};
            end else begin
              opnd_r <= mag_a_s;
              acc_r  <= {32'd0, mag_b_s};
            end
          end else begin
            if (bus.mthi) begin
              hi_r <= bus.a;
            end
            if (bus.mtlo) begin
              lo_r <= bus.a;
            end
          end
        end
        RUN: begin
          count_r <= count_r + 5'd1;
          if (is_div_r) begin
            acc_r <= div_next_s;
          end else begin
            acc_r <= mul_next_s;
          end
        end
        FIX: begin
          hi_r   <= fix_hi_s;
          lo_r   <= fix_lo_s;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed self-checking bench for multiply_divide_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_multiply_divide_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  multiply_divide_unit_if bus ();

  multiply_divide_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge where done should be high.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit with_mtlo, input bit inject);
    int cnt;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = xa;
    bus.b     = xb;
    bus.mtlo  = with_mtlo;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    bus.a     = 32'hA5A5_5A5A;
    bus.b     = 32'h1357_9BDF;
    check_value({tag, " busy_after_start"}, {63'd0, bus.busy}, 64'd1);
    check_value({tag, " done_low_at_start"}, {63'd0, bus.done}, 64'd0);
    check_value({tag, " lo_held_at_start"}, {32'd0, bus.lo}, {32'd0, model_lo});
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (inject && cnt == 5) begin
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'd1;
      end else if (inject && cnt == 6) begin
        idle_inputs();
      end
      if (cnt == 16) begin
        check_value({tag, " hi_held_mid"}, {32'd0, bus.hi}, {32'd0, model_hi});
        check_value({tag, " lo_held_mid"}, {32'd0, bus.lo}, {32'd0, model_lo});
      end
    end
    check_value({tag, " busy_cycles"}, 64'(cnt), 64'd33);
    check_value({tag, " done"}, {63'd0, bus.done}, 64'd1);
    check_value({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    check_value({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    int dn;
    total    = 0;
    bad      = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    idle_inputs();
    reset = 1'b0;
    #1;
    check_value("rst busy", {63'd0, bus.busy}, 64'd0);
    check_value("rst done", {63'd0, bus.done}, 64'd0);
    check_value("rst hi", {32'd0, bus.hi}, 64'd0);
    check_value("rst lo", {32'd0, bus.lo}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // mtlo alone
    bus.mtlo = 1'b1;
    bus.a    = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check_value("mtlo lo", {32'd0, bus.lo}, 64'h1234_5678);
    check_value("mtlo hi_untouched", {32'd0, bus.hi}, 64'd0);
    model_lo = 32'h1234_5678;

    // mthi and mtlo together
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.a    = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check_value("mthilo hi", {32'd0, bus.hi}, 64'hCAFE_F00D);
    check_value("mthilo lo", {32'd0, bus.lo}, 64'hCAFE_F00D);
    model_hi = 32'hCAFE_F00D;
    model_lo = 32'hCAFE_F00D;

    // back-to-back arithmetic ops (each starts in the done cycle of the previous one)
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("divu_zero", 2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("div_zero_neg", 2'b11, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("multu_ignore", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);
    run_op("divu_mtlo", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);
    @(negedge clk);
    check_value("done_single_pulse", {63'd0, bus.done}, 64'd0);

    // reset in the middle of an operation
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("abort busy", {63'd0, bus.busy}, 64'd0);
    check_value("abort hi", {32'd0, bus.hi}, 64'd0);
    check_value("abort lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_hi = 32'd0;
    model_lo = 32'd0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check_value("abort no_done", 64'(dn), 64'd0);
    check_value("abort lo_kept", {32'd0, bus.lo}, 64'd0);
    run_op("multu_after_rst", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
